pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the combinational ripple adder in the Hack arithmetic-logic path. It splits a DATA_WIDTH-bit add/subtract into LANE_WIDTH-bit ripple slices, with one register stage per slice. This lets wide datapaths close timing. The block carries a valid/ready handshake with backpressure and produces Hack-style status flags (carry, overflow, zero, negative) aligned with the result.

---
 rtl/hack_alu_pkg.sv | 17 +
 rtl/pipelined_adder_if.sv | 31 +++
 rtl/adder_stage.sv | 36 +++
 rtl/pipelined_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_adder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_alu_pkg.sv
// Shared types and configuration helpers for the Hack arithmetic path.
package hack_alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    ADC = 2'd1,
    SUB = 2'd2,
    SBB = 2'd3
  } adder_op_t;

  // A word must split into a whole number (at least one) of lanes.
  function automatic bit lanes_fit(int data_width, int lane_width);
    return (lane_width > 0) && (data_width >= lane_width) &&
           (data_width % lane_width == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; master drives operands,
// slave (the adder) drives results and in_ready.
interface pipelined_adder_if
  import hack_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  adder_op_t             op;
  logic                  carry_in;
  logic [DATA_WIDTH-1:0] dataA_in;
  logic [DATA_WIDTH-1:0] dataB_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
  logic                  overflow;
  logic                  zero;
  logic                  negative;

  modport master (
    output in_valid, op, carry_in, dataA_in, dataB_in, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, op, carry_in, dataA_in, dataB_in, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/adder_stage.sv
// One pipeline lane: LANE_WIDTH-bit ripple add with carry, registered sum,
// carry and valid; holds while en is low.
module adder_stage #(
  parameter int LANE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  valid_in,
  input  logic                  carry_in,
  input  logic [LANE_WIDTH-1:0] a,
  input  logic [LANE_WIDTH-1:0] b,
  output logic [LANE_WIDTH-1:0] sum_q,
  output logic                  carry_q,
  output logic                  valid_q
);

  logic [LANE_WIDTH:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {{LANE_WIDTH{1'b0}}, carry_in};

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift is race-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      sum_q   <= raw[LANE_WIDTH-1:0];
      carry_q <= raw[LANE_WIDTH];
      valid_q <= valid_in;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one adder_stage per lane, operand skew registers
// ahead of each stage, finished lanes carried behind, flags from the last stage.
module pipelined_adder
  import hack_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  pipelined_adder_if.slave bus
);

  localparam int NUM_STAGES = DATA_WIDTH / LANE_WIDTH;

  if (!lanes_fit(DATA_WIDTH, LANE_WIDTH)) begin : g_bad_cfg
    $error("pipelined_adder: DATA_WIDTH must be a positive multiple of LANE_WIDTH");
  end

  logic                  advance;
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  cin_eff;

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    b_eff   = bus.dataB_in;
    cin_eff = 1'b0;
    case (bus.op)
      ADC:     cin_eff = bus.carry_in;
      SUB: begin
        b_eff   = ~bus.dataB_in;
        cin_eff = 1'b1;
      end
      SBB: begin
        b_eff   = ~bus.dataB_in;
        cin_eff = bus.carry_in;
      end
      default: ;
    endcase
  end

  // The whole pipe moves as one; a stalled result freezes every slot behind it.
  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : stg
    // Lanes g..NUM_STAGES-1 of the operands are still unprocessed at stage g.
    localparam int UW = DATA_WIDTH - g * LANE_WIDTH;

    logic [UW-1:0]               a_in;
    logic [UW-1:0]               b_in;
    logic                        cin;
    logic                        vin;
    logic [LANE_WIDTH-1:0]       lane_q;
    logic                        cout_q;
    logic                        vout_q;
    logic [(g+1)*LANE_WIDTH-1:0] view;

    if (g == 0) begin : head
      assign a_in = bus.dataA_in;
      assign b_in = b_eff;
      assign cin  = cin_eff;
      assign vin  = bus.in_valid & bus.in_ready;
      assign view = lane_q;
    end else begin : body
      logic [g*LANE_WIDTH-1:0] done_q;

      // NOTE: data registers are reset too, so sum/flags read as a clean zero
      // result straight out of reset rather than whatever was in flight.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_in   <= '0;
          b_in   <= '0;
          done_q <= '0;
        end else if (advance) begin
          a_in   <= stg[g-1].a_in[DATA_WIDTH-(g-1)*LANE_WIDTH-1:LANE_WIDTH];
          b_in   <= stg[g-1].b_in[DATA_WIDTH-(g-1)*LANE_WIDTH-1:LANE_WIDTH];
          done_q <= stg[g-1].view;
        end
      end

      assign cin  = stg[g-1].cout_q;
      assign vin  = stg[g-1].vout_q;
      assign view = {lane_q, done_q};
    end

    adder_stage #(
      .LANE_WIDTH(LANE_WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (advance),
      .valid_in(vin),
      .carry_in(cin),
      .a       (a_in[LANE_WIDTH-1:0]),
      .b       (b_in[LANE_WIDTH-1:0]),
      .sum_q   (lane_q),
      .carry_q (cout_q),
      .valid_q (vout_q)
    );

    // Operand sign bits ride with the top lane for the overflow test.
    if (g == NUM_STAGES - 1) begin : tail
      logic a_msb_q;
      logic b_msb_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else if (advance) begin
          a_msb_q <= a_in[UW-1];
          b_msb_q <= b_in[UW-1];
        end
      end
    end
  end

  logic a_msb;
  logic b_msb;

  assign a_msb         = stg[NUM_STAGES-1].tail.a_msb_q;
  assign b_msb         = stg[NUM_STAGES-1].tail.b_msb_q;
  assign bus.out_valid = stg[NUM_STAGES-1].vout_q;
  assign bus.sum       = stg[NUM_STAGES-1].view;
  assign bus.carry     = stg[NUM_STAGES-1].cout_q;
  assign bus.overflow  = (a_msb == b_msb) && (bus.sum[DATA_WIDTH-1] != a_msb);
  assign bus.zero      = ~|bus.sum;
  assign bus.negative  = bus.sum[DATA_WIDTH-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench: a 4-stage and a 1-stage pipelined_adder driven in lockstep.
module tb_pipelined_adder;
  import hack_alu_pkg::*;

  localparam logic [20:0] RESET_RES = {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

  typedef struct {
    adder_op_t   op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  adder_op_t   op;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  vec_t vecs [9];

  always #5 clk = ~clk;

  pipelined_adder_if #(.DATA_WIDTH(16)) bus4 ();
  pipelined_adder_if #(.DATA_WIDTH(16)) bus1 ();

  assign bus4.in_valid  = in_valid;
  assign bus4.op        = op;
  assign bus4.carry_in  = cin;
  assign bus4.dataA_in  = a;
  assign bus4.dataB_in  = b;
  assign bus4.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.op        = op;
  assign bus1.carry_in  = cin;
  assign bus1.dataA_in  = a;
  assign bus1.dataB_in  = b;
  assign bus1.out_ready = out_ready;

  pipelined_adder #(.DATA_WIDTH(16), .LANE_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  pipelined_adder #(.DATA_WIDTH(16), .LANE_WIDTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  function automatic logic [20:0] res4();
    return {bus4.out_valid, bus4.sum, bus4.carry, bus4.overflow, bus4.zero, bus4.negative};
  endfunction

  function automatic logic [20:0] res1();
    return {bus1.out_valid, bus1.sum, bus1.carry, bus1.overflow, bus1.zero, bus1.negative};
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op        = ADD;
    cin       = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (res4() !== RESET_RES || bus4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_4stage got=%h rdy=%b exp=%h rdy=1", res4(), bus4.in_ready, RESET_RES);
    end
    checks++;
    if (res1() !== RESET_RES || bus1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_1stage got=%h rdy=%b exp=%h rdy=1", res1(), bus1.in_ready, RESET_RES);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [20:0] exp;
    vecs[0] = '{ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1] = '{ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{ADC, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{ADD, 16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 1'b0};
    vecs[6] = '{SBB, 16'h0000, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{SBB, 16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[8] = '{ADC, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      op       = vecs[i].op;
      a        = vecs[i].a;
      b        = vecs[i].b;
      cin      = vecs[i].cin;
      in_valid = 1'b1;
      exp = {1'b1, vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].s == 16'h0000, vecs[i].s[15]};
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (res1() !== exp) begin
        errors++;
        $display("FAIL arith_1stage[%0d] got=%h exp=%h", i, res1(), exp);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus4.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early[%0d] out_valid=%b exp=0", i, bus4.out_valid);
      end
      @(negedge clk);
      checks++;
      if (res4() !== exp) begin
        errors++;
        $display("FAIL arith_4stage[%0d] got=%h exp=%h", i, res4(), exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ev;
    logic [15:0] es;
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        op       = ADD;
        cin      = 1'b0;
        a        = 16'(c);
        b        = 16'(c * 16'h1111);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      ev = (c >= 3) && (c <= 10);
      es = 16'((c - 3) * 16'h1112);
      checks++;
      if (bus4.out_valid !== ev || (ev && bus4.sum !== es)) begin
        errors++;
        $display("FAIL b2b[%0d] valid=%b sum=%h exp valid=%b sum=%h", c, bus4.out_valid, bus4.sum, ev, es);
      end
    end
  endtask

  task automatic test_stall();
    int          di = 0;
    int          ri = 0;
    logic [15:0] es;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      if (di < 8) begin
        in_valid = 1'b1;
        op       = ADD;
        cin      = 1'b0;
        a        = 16'(16'h0101 * di);
        b        = 16'h1000;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      es = 16'h1000 + 16'(16'h0101 * ri);
      if (!out_ready) begin
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0 || bus4.sum !== es) begin
          errors++;
          $display("FAIL stall_hold[%0d] valid=%b rdy=%b sum=%h exp valid=1 rdy=0 sum=%h",
                   c, bus4.out_valid, bus4.in_ready, bus4.sum, es);
        end
      end else if (bus4.out_valid === 1'b1) begin
        checks++;
        if (ri >= 8 || bus4.sum !== es) begin
          errors++;
          $display("FAIL stall_order[%0d] sum=%h exp=%h idx=%0d", c, bus4.sum, es, ri);
        end
        ri++;
      end
      if (in_valid && bus4.in_ready) di++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (ri != 8) begin
      errors++;
      $display("FAIL stall_count got=%0d exp=8", ri);
    end
  endtask

  task automatic test_reset_in_flight();
    logic [20:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      op       = ADD;
      cin      = 1'b0;
      a        = 16'(16'h0011 * (k + 1));
      b        = 16'h0100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.sum !== 16'h0111) begin
      errors++;
      $display("FAIL pre_reset valid=%b sum=%h exp valid=1 sum=0111", bus4.out_valid, bus4.sum);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (res4() !== RESET_RES || bus4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got=%h rdy=%b exp=%h rdy=1", res4(), bus4.in_ready, RESET_RES);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ghost_after_reset[%0d] out_valid=%b exp=0", c, bus4.out_valid);
      end
    end
    in_valid = 1'b1;
    op       = ADD;
    a        = 16'h0F0F;
    b        = 16'h00F1;
    exp      = {1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (res4() !== exp) begin
      errors++;
      $display("FAIL post_reset_txn got=%h exp=%h", res4(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
